// File: rtl/spi_dac_scheduler.sv
// spi_dac_scheduler
//   Shares one spiword DAC driver between two command requesters (UART
//   parser = req0, SPI-slave path = req1). The block arbitrates the
//   requests, issues the spiword start pulse, owns DAC chip-select framing,
//   and enforces a programmable dwell after every transfer before the next
//   command can be granted.
//
// Parameters
//   WORD_W    width of value, count and spi_tx
//   SHIFT     right shift applied to the value before it is sent (zero fill)
//   MIN_DWELL lower bound on the post-transfer dwell, in cycles
//
// Build option
//   FIXED_PRIO_EN  when defined, req0 always wins a tie; otherwise the tie is
//                  resolved round-robin against the most recent grant.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   reqN_valid/ready         command handshake (ready is combinational)
//   reqN_count/value         dwell cycles after the transfer / DAC value
//   spi_we, spi_tx           start pulse and word to spiword
//   spi_running              spiword is shifting
//   csn                      DAC chip select, active low
//   busy                     scheduler is not idle
//   grant_id                 requester most recently granted
module spi_dac_scheduler #(
  parameter int WORD_W    = 16,
  parameter int SHIFT     = 2,
  parameter int MIN_DWELL = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WORD_W-1:0] req0_count,
  input  logic [WORD_W-1:0] req0_value,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WORD_W-1:0] req1_count,
  input  logic [WORD_W-1:0] req1_value,
  output logic              spi_we,
  output logic [WORD_W-1:0] spi_tx,
  input  logic              spi_running,
  output logic              csn,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [WORD_W-1:0] MIN_DWELL_W = WORD_W'(MIN_DWELL);
  localparam logic [WORD_W-1:0] ONE_W       = WORD_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_SPI = 2'd2,
    DWELL    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              spi_we_d;
  logic              csn_d;
  logic [WORD_W-1:0] spi_tx_d;
  logic              grant_d;
  logic              last_q, last_d;
  logic              first_q, first_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] count_q, count_d;
  logic              sel;
  logic              accept;

  // Dwell length is the requested count, floored at MIN_DWELL.
  function automatic logic [WORD_W-1:0] dwell_len(input logic [WORD_W-1:0] c);
    return (c < MIN_DWELL_W) ? MIN_DWELL_W : c;
  endfunction

  // Word actually sent: value shifted right, zeros in from the MSB.
  function automatic logic [WORD_W-1:0] tx_word(input logic [WORD_W-1:0] v);
    return v >> SHIFT;
  endfunction

  // Requester selection; sel=1 means req1.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef FIXED_PRIO_EN
      sel = 1'b0;
`else
      sel = ~last_q;
`endif
    end else begin
      sel = req1_valid;
    end
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !sel;
  assign req1_ready = (state_q == IDLE) && req1_valid && sel;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    spi_we_d = 1'b0;
    csn_d    = csn;
    spi_tx_d = spi_tx;
    grant_d  = grant_id;
    last_d   = last_q;
    first_d  = first_q;
    cnt_d    = cnt_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SEND;
          spi_we_d = 1'b1;
          csn_d    = 1'b0;
          spi_tx_d = sel ? tx_word(req1_value) : tx_word(req0_value);
          count_d  = sel ? req1_count : req0_count;
          grant_d  = sel;
          last_d   = sel;
        end
      end
      SEND: begin
        state_d = WAIT_SPI;
        first_d = 1'b1;
      end
      WAIT_SPI: begin
        // spiword's running flag is registered, so it cannot be trusted
        // on the first cycle after the start pulse.
        if (first_q) begin
          first_d = 1'b0;
        end else if (!spi_running) begin
          state_d = DWELL;
          cnt_d   = dwell_len(count_q);
          csn_d   = 1'b1;
        end
      end
      DWELL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - ONE_W;
        end
      end
      default: begin
        state_d = IDLE;
        csn_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      spi_we   <= 1'b0;
      spi_tx   <= '0;
      csn      <= 1'b1;
      grant_id <= 1'b0;
      last_q   <= 1'b1;
      first_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      spi_we   <= spi_we_d;
      spi_tx   <= spi_tx_d;
      csn      <= csn_d;
      grant_id <= grant_d;
      last_q   <= last_d;
      first_q  <= first_d;
      cnt_q    <= cnt_d;
    end
  end

  // Latched command count is pure data and only read after acceptance.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

endmodule

// File: tb/tb_spi_dac_scheduler.sv
module tb_spi_dac_scheduler;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic        r0v = 0, r1v = 0;
  logic [15:0] r0c = 0, r0d = 0, r1c = 0, r1d = 0;
  logic        r0rdy, r1rdy, we, csn, busy, gid, run;
  logic [15:0] tx;
  int          run_cnt;

  // DUT B: MIN_DWELL = 10
  logic        b_r0v = 0, b_r1v = 0;
  logic [15:0] b_r0c = 0, b_r0d = 0, b_r1c = 0, b_r1d = 0;
  logic        b_r0rdy, b_r1rdy, b_we, b_csn, b_busy, b_gid, b_run;
  logic [15:0] b_tx;
  int          b_run_cnt;

  spi_dac_scheduler dut_a (
    .clk(clk), .resetn(resetn),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_count(r0c), .req0_value(r0d),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_count(r1c), .req1_value(r1d),
    .spi_we(we), .spi_tx(tx), .spi_running(run),
    .csn(csn), .busy(busy), .grant_id(gid)
  );

  spi_dac_scheduler #(.MIN_DWELL(10)) dut_b (
    .clk(clk), .resetn(resetn),
    .req0_valid(b_r0v), .req0_ready(b_r0rdy), .req0_count(b_r0c), .req0_value(b_r0d),
    .req1_valid(b_r1v), .req1_ready(b_r1rdy), .req1_count(b_r1c), .req1_value(b_r1d),
    .spi_we(b_we), .spi_tx(b_tx), .spi_running(b_run),
    .csn(b_csn), .busy(b_busy), .grant_id(b_gid)
  );

  // spiword stand-ins: registered running flag, 4 shift cycles per start
  always @(posedge clk or negedge resetn) begin
    if (!resetn) run_cnt <= 0;
    else if (we) run_cnt <= 4;
    else if (run_cnt != 0) run_cnt <= run_cnt - 1;
  end
  assign run = (run_cnt != 0);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) b_run_cnt <= 0;
    else if (b_we) b_run_cnt <= 4;
    else if (b_run_cnt != 0) b_run_cnt <= b_run_cnt - 1;
  end
  assign b_run = (b_run_cnt != 0);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v0, v1;
    logic [15:0] c0, val0, c1, val1;
    logic        r0, r1;
    logic [15:0] tx;
    logic        gid;
    int          dwell;
  } vec_t;

  vec_t vecs[5];

  // One transaction on DUT A from idle; checks handshake, SEND outputs,
  // csn-low length (SEND + 5 WAIT_SPI cycles) and dwell length.
  task automatic run_vec(input vec_t v, input int idx);
    int lo, n, guard, extra_we;
    string s;
    @(negedge clk);
    r0v = v.v0; r1v = v.v1; r0c = v.c0; r0d = v.val0; r1c = v.c1; r1d = v.val1;
    #1;
    s = $sformatf("v%0d", idx);
    chk({s, "_ready0"}, r0rdy, v.r0);
    chk({s, "_ready1"}, r1rdy, v.r1);
    @(negedge clk);
    r0v = 0; r1v = 0;
    chk({s, "_spi_we"}, we, 1'b1);
    chk({s, "_spi_tx"}, tx, v.tx);
    chk({s, "_grant_id"}, gid, v.gid);
    chk({s, "_csn_send"}, csn, 1'b0);
    lo = 1; n = 0; guard = 0; extra_we = 0;
    forever begin
      @(negedge clk);
      guard++;
      if (we) extra_we++;
      if (!csn) lo++;
      else if (busy) n++;
      else break;
      if (guard > 1000) break;
    end
    chk({s, "_timeout"}, guard > 1000, 1'b0);
    chk({s, "_extra_we"}, extra_we, 0);
    chk({s, "_csn_low_cycles"}, lo, 6);
    chk({s, "_dwell_cycles"}, n, v.dwell);
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (busy && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic b_dwell(input logic [15:0] cnt, input int exp);
    int n, guard;
    @(negedge clk);
    b_r0v = 1; b_r0c = cnt; b_r0d = 16'h0100;
    #1;
    chk("b_ready0", b_r0rdy, 1'b1);
    @(negedge clk);
    b_r0v = 0;
    n = 0; guard = 0;
    forever begin
      @(negedge clk);
      guard++;
      if (b_csn && b_busy) n++;
      else if (!b_busy) break;
      if (guard > 1000) break;
    end
    chk("b_timeout", guard > 1000, 1'b0);
    chk("b_dwell_cycles", n, exp);
  endtask

  initial begin
    logic g[4];
    logic exp_g[4];
    int got, dbl, guard, k;

    // last_grant resets to 1, so the first tie goes to req0.
    vecs[0] = '{v0:1, v1:0, c0:16'd3, val0:16'h1234, c1:0, val1:0,
                r0:1, r1:0, tx:16'h048D, gid:0, dwell:4};
    vecs[1] = '{v0:0, v1:1, c0:0, val0:0, c1:16'd0, val1:16'hFFFF,
                r0:0, r1:1, tx:16'h3FFF, gid:1, dwell:1};
    vecs[2] = '{v0:1, v1:1, c0:16'd1, val0:16'h0003, c1:16'd2, val1:16'h8000,
                r0:1, r1:0, tx:16'h0000, gid:0, dwell:2};
`ifdef FIXED_PRIO_EN
    vecs[3] = '{v0:1, v1:1, c0:16'd0, val0:16'hABCD, c1:16'd5, val1:16'h5678,
                r0:1, r1:0, tx:16'h2AF3, gid:0, dwell:1};
`else
    vecs[3] = '{v0:1, v1:1, c0:16'd0, val0:16'hABCD, c1:16'd5, val1:16'h5678,
                r0:0, r1:1, tx:16'h159E, gid:1, dwell:6};
`endif
    vecs[4] = '{v0:1, v1:0, c0:16'd0, val0:16'h0004, c1:0, val1:0,
                r0:1, r1:0, tx:16'h0001, gid:0, dwell:1};

    // Reset state
    #12;
    chk("rst_csn", csn, 1'b1);
    chk("rst_spi_we", we, 1'b0);
    chk("rst_spi_tx", tx, 16'h0000);
    chk("rst_grant_id", gid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    resetn = 1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Both valid continuously, count=0; last grant so far was req0.
`ifdef FIXED_PRIO_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
    @(negedge clk);
    r0v = 1; r1v = 1; r0c = 0; r1c = 0; r0d = 16'h0040; r1d = 16'h0080;
    got = 0; dbl = 0; guard = 0;
    while (got < 4 && guard < 400) begin
      #1;
      if (r0rdy && r1rdy) dbl++;
      if (r0rdy || r1rdy) begin
        g[got] = r1rdy;
        got++;
      end
      @(negedge clk);
      guard++;
    end
    r0v = 0; r1v = 0;
    chk("rr_grants", got, 4);
    chk("rr_double_ready", dbl, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), g[i], exp_g[i]);
    chk("rr_last_grant_id", gid, exp_g[3]);
    wait_idle("rr_idle");

    // Reset asserted mid-WAIT_SPI
    @(negedge clk);
    r0v = 1; r0c = 16'd3; r0d = 16'h1234;
    @(negedge clk);   // SEND
    r0v = 0;
    @(negedge clk);   // first WAIT_SPI cycle
    chk("pre_rst_csn", csn, 1'b0);
    resetn = 0;
    #1;
    chk("async_rst_csn", csn, 1'b1);
    chk("async_rst_spi_we", we, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    @(negedge clk);
    resetn = 1;
    #1;
    chk("post_rst_busy", busy, 1'b0);
    run_vec('{v0:0, v1:1, c0:0, val0:0, c1:16'd1, val1:16'h0010,
              r0:0, r1:1, tx:16'h0004, gid:1, dwell:2}, 5);

    // MIN_DWELL floor on DUT B
    b_dwell(16'd2, 11);
    b_dwell(16'd20, 21);

    // Maximum count: 65536 dwell cycles, waiting request held off.
    @(negedge clk);
    r0v = 1; r0c = 16'hFFFF; r0d = 16'h0000;
    #1;
    chk("max_ready0", r0rdy, 1'b1);
    @(negedge clk);   // SEND
    r0v = 0; r1v = 1; r1c = 0; r1d = 16'h0004;
    guard = 0;
    while (!csn && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("max_csn_rise", csn, 1'b1);
    k = 1;
    while (!r1rdy && k < 70000) begin
      @(negedge clk);
      k++;
    end
    chk("max_dwell_to_ready", k, 65537);
    @(negedge clk);
    r1v = 0;
    chk("max_next_spi_tx", tx, 16'h0001);
    wait_idle("max_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
